spi_frame_buffer: RTL and testbench

Parametrised SPI-slave frame buffer for the compressive-sensing signal path: captures a frame of up to DEPTH words of DATA_W bits from the SPI master, holds it, then returns it word-for-word in a following SSEL transaction. It generalises the fixed 64×8 receive-then-send block. Beyond that block it adds:
- configurable width and depth
- variable-length (partial) frames
- input synchronisation
- retransmit on an aborted read
- sticky overflow/underrun status

---
 rtl/spi_frame_buffer_if.sv | 10 +
 rtl/spi_frame_buffer.sv | 167 ++++++++++++++++
 tb/tb_spi_frame_buffer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_buffer_if.sv
// SPI pin bundle for the frame buffer: the master drives SCK/SSEL/MOSI, the slave drives MISO.
interface spi_frame_buffer_if;
  logic SCK;
  logic SSEL;
  logic MOSI;
  logic MISO;

  modport master (output SCK, output SSEL, output MOSI, input MISO);
  modport slave  (input SCK, input SSEL, input MOSI, output MISO);
endinterface

// File: rtl/spi_frame_buffer.sv
// SPI-slave (mode 0) frame buffer: captures up to DEPTH words in one SSEL transaction,
// then returns the held frame word-for-word in a later transaction.
module spi_frame_buffer #(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 64,
  localparam int LEN_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_frame_buffer_if.slave spi,
  input  logic              clr_flags,
  output logic              frame_ready,
  output logic [LEN_W-1:0]  frame_len,
  output logic              busy,
  output logic              overflow,
  output logic              underrun
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [LEN_W-1:0] FULL     = LEN_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECEIVE, LOADED, TRANSMIT} stateT;
  stateT state, stateNext;

  logic [2:0]        sckPipe, sselPipe;
  logic [1:0]        mosiPipe;
  logic              sckRise, sckFall, sselFall, sselRise, sselLow;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-2:0] rxShift;
  logic [DATA_W-1:0] rxWord, txShift;
  logic [CNT_W-1:0]  bitCnt;
  logic              bitLast;
  logic [LEN_W-1:0]  wrPtr, wrNext, rdPtr, rdNext, frameLen;
  logic              rxDone, txDone, setOvf, setUnd;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  // SSEL stages reset low: a select already asserted at reset release never looks like a fresh fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sckPipe  <= '0;
      sselPipe <= '0;
      mosiPipe <= '0;
    end else begin
      sckPipe  <= {sckPipe[1:0], spi.SCK};
      sselPipe <= {sselPipe[1:0], spi.SSEL};
      mosiPipe <= {mosiPipe[0], spi.MOSI};
    end
  end

  assign sckRise  =  sckPipe[1]  & ~sckPipe[2];
  assign sckFall  = ~sckPipe[1]  &  sckPipe[2];
  assign sselFall = ~sselPipe[1] &  sselPipe[2];
  assign sselRise =  sselPipe[1] & ~sselPipe[2];
  assign sselLow  = ~sselPipe[1];
  assign rxWord   = {rxShift, mosiPipe[1]};
  assign bitLast  = (bitCnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext = state;
    rxDone    = 1'b0;
    txDone    = 1'b0;
    setOvf    = 1'b0;
    setUnd    = 1'b0;
    wrNext    = wrPtr;
    rdNext    = rdPtr;
    case (state)
      IDLE: if (sselFall) stateNext = RECEIVE;
      RECEIVE: begin
        rxDone = sckRise && bitLast;
        if (rxDone) wrNext = wrPtr + LEN_W'(1);
        // A word completing together with ssel_rise is counted before choosing the next state.
        if (wrNext == FULL)  stateNext = LOADED;
        else if (sselRise)   stateNext = (wrNext != '0) ? LOADED : IDLE;
      end
      LOADED: begin
        setOvf = sckRise && sselLow && bitLast;
        if (sselFall) stateNext = TRANSMIT;
      end
      TRANSMIT: begin
        txDone = sckFall && bitLast;
        if (txDone && (rdPtr < frameLen)) rdNext = rdPtr + LEN_W'(1);
        setUnd = txDone && (rdPtr >= frameLen);
        if (sselRise) stateNext = (rdNext >= frameLen) ? IDLE : LOADED;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      bitCnt   <= '0;
      rxShift  <= '0;
      txShift  <= '0;
      frameLen <= '0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      // Sets follow the clear so a coincident flag event wins over clr_flags.
      if (clr_flags) begin
        overflow <= 1'b0;
        underrun <= 1'b0;
      end
      if (setOvf) overflow <= 1'b1;
      if (setUnd) underrun <= 1'b1;

      case (state)
        IDLE: begin
          wrPtr  <= '0;
          bitCnt <= '0;
        end
        RECEIVE: begin
          wrPtr <= wrNext;
          if (sckRise) begin
            rxShift <= rxWord[DATA_W-2:0];
            bitCnt  <= bitLast ? '0 : bitCnt + CNT_W'(1);
          end
          if (stateNext == LOADED) begin
            frameLen <= wrNext;
            bitCnt   <= '0;
          end
        end
        LOADED: begin
          if (sckRise && sselLow) bitCnt <= bitLast ? '0 : bitCnt + CNT_W'(1);
          if (stateNext == TRANSMIT) begin
            rdPtr   <= '0;
            bitCnt  <= '0;
            txShift <= mem[0];
          end
        end
        TRANSMIT: begin
          rdPtr <= rdNext;
          if (sckFall) begin
            if (bitLast) begin
              bitCnt  <= '0;
              txShift <= (rdNext < frameLen) ? mem[rdNext[ADDR_W-1:0]] : '0;
            end else begin
              bitCnt  <= bitCnt + CNT_W'(1);
              txShift <= {txShift[DATA_W-2:0], 1'b0};
            end
          end
          if (stateNext != TRANSMIT) bitCnt   <= '0;
          if (stateNext == IDLE)     frameLen <= '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: frame storage has no reset; frame_len gates every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (rxDone) mem[wrPtr[ADDR_W-1:0]] <= rxWord;
  end

  assign busy        = (state == RECEIVE) || (state == TRANSMIT);
  assign frame_ready = (state == LOADED)  || (state == TRANSMIT);
  assign frame_len   = frameLen;
  assign spi.MISO    = (state == TRANSMIT) ? txShift[DATA_W-1] : 1'b0;
endmodule

// File: tb/tb_spi_frame_buffer.sv
// Drives an 8x64 and a 12x16 frame buffer from the same SPI pins and checks both against a
// frame-level model: word counts from bit counts, held frame contents, flags and state.
module tb_spi_frame_buffer;
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst_n, sck, ssel, mosi, clr;
  always #5 clk = ~clk;

  spi_frame_buffer_if spiA ();
  spi_frame_buffer_if spiB ();
  assign spiA.SCK  = sck;
  assign spiA.SSEL = ssel;
  assign spiA.MOSI = mosi;
  assign spiB.SCK  = sck;
  assign spiB.SSEL = ssel;
  assign spiB.MOSI = mosi;

  logic       readyA, busyA, ovfA, undA;
  logic [6:0] lenA;
  logic       readyB, busyB, ovfB, undB;
  logic [4:0] lenB;

  spi_frame_buffer #(.DATA_W(8), .DEPTH(64)) dutA (
    .clk(clk), .rst_n(rst_n), .spi(spiA), .clr_flags(clr), .frame_ready(readyA),
    .frame_len(lenA), .busy(busyA), .overflow(ovfA), .underrun(undA));

  spi_frame_buffer #(.DATA_W(12), .DEPTH(16)) dutB (
    .clk(clk), .rst_n(rst_n), .spi(spiB), .clr_flags(clr), .frame_ready(readyB),
    .frame_len(lenB), .busy(busyB), .overflow(ovfB), .underrun(undB));

  int   checks = 0;
  int   errors = 0;
  int   mFrame [2][64];
  bit   mLoaded [2];
  int   mLen [2];
  bit   mOvf [2];
  bit   mUnd [2];
  bit   mosiQ [$];
  logic rxA [$];
  logic rxB [$];

  function automatic int dwOf(input int k);
    return (k == 0) ? 8 : 12;
  endfunction

  function automatic int depthOf(input int k);
    return (k == 0) ? 64 : 16;
  endfunction

  function automatic string nameOf(input int k);
    return (k == 0) ? "A" : "B";
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkStatus(input int k, input string tag);
    logic [63:0] rdy, len, bsy, ovf, und, miso;
    if (k == 0) begin
      rdy = 64'(readyA); len = 64'(lenA); bsy = 64'(busyA);
      ovf = 64'(ovfA);   und = 64'(undA); miso = 64'(spiA.MISO);
    end else begin
      rdy = 64'(readyB); len = 64'(lenB); bsy = 64'(busyB);
      ovf = 64'(ovfB);   und = 64'(undB); miso = 64'(spiB.MISO);
    end
    check($sformatf("%s.%s.ready", tag, nameOf(k)), rdy, 64'(mLoaded[k]));
    check($sformatf("%s.%s.len", tag, nameOf(k)), len, 64'(mLen[k]));
    check($sformatf("%s.%s.busy", tag, nameOf(k)), bsy, 64'(0));
    check($sformatf("%s.%s.ovf", tag, nameOf(k)), ovf, 64'(mOvf[k]));
    check($sformatf("%s.%s.und", tag, nameOf(k)), und, 64'(mUnd[k]));
    check($sformatf("%s.%s.miso", tag, nameOf(k)), miso, 64'(0));
  endtask

  function automatic int wordAt(input int w, input int dw);
    int v = 0;
    for (int b = 0; b < dw; b++) v = (v << 1) | int'(mosiQ[w * dw + b]);
    return v;
  endfunction

  function automatic logic [63:0] rxWordOf(input int k, input int w, input int dw);
    logic [63:0] v = '0;
    for (int b = 0; b < dw; b++) v = {v[62:0], (k == 0) ? rxA[w * dw + b] : rxB[w * dw + b]};
    return v;
  endfunction

  // Whole-transaction model: an idle buffer captures floor(bits/dw) words, a loaded one replays.
  task automatic modelXfer(input int k, input string tag);
    int dw    = dwOf(k);
    int depth = depthOf(k);
    int words = mosiQ.size() / dw;
    if (!mLoaded[k]) begin
      if (words > 0) begin
        mLen[k] = (words < depth) ? words : depth;
        for (int w = 0; w < mLen[k]; w++) mFrame[k][w] = wordAt(w, dw);
        mLoaded[k] = 1'b1;
        if (words > depth) mOvf[k] = 1'b1;
      end
    end else begin
      for (int w = 0; w < words; w++)
        check($sformatf("%s.%s.word%0d", tag, nameOf(k), w), rxWordOf(k, w, dw),
              (w < mLen[k]) ? 64'(mFrame[k][w]) : 64'(0));
      if (words > mLen[k]) mUnd[k] = 1'b1;
      if (words >= mLen[k]) begin
        mLoaded[k] = 1'b0;
        mLen[k]    = 0;
      end
    end
    checkStatus(k, tag);
  endtask

  task automatic shiftBits(input int from, input int n);
    for (int i = from; i < from + n; i++) begin
      mosi = mosiQ[i];
      repeat (HALF) @(negedge clk);
      rxA.push_back(spiA.MISO);
      rxB.push_back(spiB.MISO);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input string tag);
    rxA.delete();
    rxB.delete();
    ssel = 1'b0;
    repeat (6) @(negedge clk);
    check({tag, ".A.busyOn"}, 64'(busyA), 64'(1));
    check({tag, ".B.busyOn"}, 64'(busyB), 64'(1));
    shiftBits(0, mosiQ.size());
    repeat (HALF) @(negedge clk);
    ssel = 1'b1;
    repeat (8) @(negedge clk);
    modelXfer(0, tag);
    modelXfer(1, tag);
  endtask

  task automatic seqWords(input int n, input int dw);
    mosiQ.delete();
    for (int v = 0; v < n; v++)
      for (int b = dw - 1; b >= 0; b--) mosiQ.push_back(bit'((v >> b) & 1));
  endtask

  task automatic randBits(input int n);
    mosiQ.delete();
    repeat (n) mosiQ.push_back(bit'($urandom_range(0, 1)));
  endtask

  task automatic pulseClr(input string tag);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      mOvf[k] = 1'b0;
      mUnd[k] = 1'b0;
      checkStatus(k, tag);
    end
  endtask

  task automatic resetModels();
    for (int k = 0; k < 2; k++) begin
      mLoaded[k] = 1'b0;
      mLen[k]    = 0;
      mOvf[k]    = 1'b0;
      mUnd[k]    = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; sck = 1'b0; ssel = 1'b1; mosi = 1'b0; clr = 1'b0;
    resetModels();
    repeat (4) @(negedge clk);
    checkStatus(0, "reset");
    checkStatus(1, "reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    seqWords(64, 8); xfer("fill64");
    randBits(512);   xfer("read64");
    pulseClr("clr1");

    randBits(40); xfer("fill5");
    randBits(56); xfer("read7");
    pulseClr("clr2");

    randBits(66 * 8); xfer("fill66");
    randBits(512);    xfer("read66");
    pulseClr("clr3");

    randBits(80); xfer("fill10");
    randBits(24); xfer("abort3");
    randBits(80); xfer("read10");

    randBits(29); xfer("fill3p");
    randBits(24); xfer("read3p");

    // Reset mid-receive with SSEL held low through release: that transaction must be ignored.
    randBits(24);
    ssel = 1'b0;
    repeat (6) @(negedge clk);
    shiftBits(0, 16);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    resetModels();
    checkStatus(0, "midRst");
    checkStatus(1, "midRst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    shiftBits(16, 8);
    repeat (HALF) @(negedge clk);
    ssel = 1'b1;
    repeat (8) @(negedge clk);
    checkStatus(0, "rstIgnored");
    checkStatus(1, "rstIgnored");

    seqWords(64, 8); xfer("refill64");
    randBits(512);   xfer("reread64");
    pulseClr("clr4");

    seqWords(16, 12); xfer("fill16w12");
    randBits(192);    xfer("read16w12");
    pulseClr("clr5");

    for (int r = 0; r < 4; r++) begin
      randBits(int'($urandom_range(1, 20)) * 8 + int'($urandom_range(0, 7)));
      xfer($sformatf("rndW%0d", r));
      randBits(int'($urandom_range(1, 24)) * 8);
      xfer($sformatf("rndR%0d", r));
    end
    pulseClr("clr6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end
endmodule
